wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// wb_cmd_master: single-outstanding Wishbone classic initiator driven by a
// valid/ready command port and returning status/data on a response port.
// Revision: 1.0
// ============================================================================
module wb_cmd_master #(
  parameter int ADR_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic [1:0]       rsp_status_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [1:0]  ST_OK     = 2'b00;
  localparam logic [1:0]  ST_ERR    = 2'b01;
  localparam logic [1:0]  ST_TMO    = 2'b10;

  state_e             state_q, state_d;
  logic               live_q, live_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic [1:0]         rsp_st_q, rsp_st_d;

  // live_q keeps cmd_ready_o low until the first edge after reset release.
  assign cmd_ready_o  = live_q && (state_q == S_IDLE);
  assign wbm_cyc_o    = (state_q == S_BUS);
  assign wbm_stb_o    = (state_q == S_BUS);
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_st_q;

  always_comb begin
    state_d   = state_q;
    live_d    = 1'b1;
    cnt_d     = cnt_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_st_d  = rsp_st_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cnt_d   = 16'd0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // err beats ack, and either beats a timeout landing on the same cycle
        if (wbm_err_i) begin
          rsp_st_d  = ST_ERR;
          rsp_dat_d = 32'd0;
          state_d   = S_RESP;
        end else if (wbm_ack_i) begin
          rsp_st_d  = ST_OK;
          rsp_dat_d = we_q ? 32'd0 : wbm_dat_i;
          state_d   = S_RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          rsp_st_d  = ST_TMO;
          rsp_dat_d = 32'd0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= S_IDLE;
      live_q    <= 1'b0;
      cnt_q     <= 16'd0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      adr_q     <= '0;
      dat_q     <= 32'd0;
      rsp_dat_q <= 32'd0;
      rsp_st_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_st_q  <= rsp_st_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_wb_cmd_master: directed transactions checked against a transaction-level
// timeline model every cycle, plus literal expectations per scenario.
// Revision: 1.0
// ============================================================================
module tb_wb_cmd_master;

  localparam int TMO    = 8;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        clk;
  logic        rstn;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i, wbm_err_i;
  logic [31:0] wbm_dat_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;

  wb_cmd_master #(.ADR_W(32), .TIMEOUT(TMO)) dut (
    .wb_clk_i     (clk),
    .wb_rstn_i    (rstn),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_sel_i    (cmd_sel_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dat_i    (cmd_dat_i),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .wbm_dat_i    (wbm_dat_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_status_o (rsp_status_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_no = 0;
  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_no);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          nb;    // number of cycles cyc/stb must stay high
    logic [31:0] rdat;
    logic [1:0]  st;
  } txn_t;

  txn_t exp_q[$];

  // Expected outcome of one transaction from the responder script alone.
  function automatic txn_t predict(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                   input logic [31:0] dat, input int kind, input int waits,
                                   input logic [31:0] rdata);
    txn_t t;
    t.we = we; t.sel = sel; t.adr = adr; t.dat = dat;
    if (kind == K_NONE) begin
      t.nb = TMO + 1; t.st = 2'b10; t.rdat = 32'd0;
    end else begin
      t.nb   = waits + 1;
      t.st   = (kind == K_ACK) ? 2'b00 : 2'b01;
      t.rdat = (kind == K_ACK && !we) ? rdata : 32'd0;
    end
    return t;
  endfunction

  // Compare process: timeline of the transaction in flight, measured in
  // cycles since acceptance.
  txn_t cur;
  bit   busy = 1'b0;
  int   age  = 0;
  bit   e_cyc, e_rsp;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("rst_stb", 32'(wbm_stb_o), 32'd0);
      chk("rst_we", 32'(wbm_we_o), 32'd0);
      chk("rst_sel", 32'(wbm_sel_o), 32'd0);
      chk("rst_adr", wbm_adr_o, 32'd0);
      chk("rst_wdat", wbm_dat_o, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_dat", rsp_dat_o, 32'd0);
      chk("rst_rsp_status", 32'(rsp_status_o), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
      busy = 1'b0;
      exp_q.delete();
    end else begin
      if (busy) age++;
      e_cyc = busy && age >= 1 && age <= cur.nb;
      e_rsp = busy && age > cur.nb;
      chk("cmd_ready", 32'(cmd_ready_o), 32'(!busy));
      chk("cyc", 32'(wbm_cyc_o), 32'(e_cyc));
      chk("stb", 32'(wbm_stb_o), 32'(e_cyc));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
      if (e_cyc) begin
        chk("bus_we", 32'(wbm_we_o), 32'(cur.we));
        chk("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
        chk("bus_adr", wbm_adr_o, cur.adr);
        chk("bus_dat", wbm_dat_o, cur.dat);
      end
      if (e_rsp) begin
        chk("rsp_dat", rsp_dat_o, cur.rdat);
        chk("rsp_status", 32'(rsp_status_o), 32'(cur.st));
      end
      if (!busy && cmd_valid_i) begin
        if (exp_q.size() == 0) begin
          chk("model_has_txn", 32'd0, 32'd1);
        end else begin
          cur  = exp_q.pop_front();
          busy = 1'b1;
          age  = 0;
        end
      end else if (e_rsp && rsp_ready_i) begin
        busy = 1'b0;
      end
    end
  end

  // One command: offer, act as responder on the bus, then consume the response.
  task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input int kind, input int waits,
                        input logic [31:0] rdata, input int hold, input bit noise,
                        output int ncyc, output int acc_at,
                        output logic [31:0] got_dat, output logic [1:0] got_st);
    int guard;
    bit done;
    exp_q.push_back(predict(we, sel, adr, dat, kind, waits, rdata));
    rsp_ready_i = (hold == 0);
    cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
    cmd_valid_i = 1'b1;
    ncyc = 0; acc_at = -1; got_dat = 32'd0; got_st = 2'b11;
    guard = 0;
    while (acc_at < 0 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (cmd_ready_o) acc_at = cyc_no;
    end
    if (acc_at < 0) begin
      chk("accept_wait", 32'd0, 32'd1);
      @(posedge clk); #1 cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    done = 1'b0; guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
      if (wbm_cyc_o) begin
        ncyc++;
        wbm_ack_i = (kind == K_ACK || kind == K_BOTH) && (ncyc == waits + 1);
        wbm_err_i = (kind == K_ERR || kind == K_BOTH) && (ncyc == waits + 1);
        wbm_dat_i = rdata;
      end else begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'hDEAD_0BAD;
        if (ncyc > 0) done = 1'b1;
      end
    end
    if (!done) chk("bus_end_wait", 32'd0, 32'd1);
    if (hold > 0) begin
      // responder noise while waiting for the response to be taken
      wbm_ack_i = noise; wbm_err_i = noise;
      repeat (hold) @(posedge clk);
      #1 wbm_ack_i = 1'b0; wbm_err_i = 1'b0; rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    got_dat = rsp_dat_o;
    got_st  = rsp_status_o;
    @(posedge clk); #1;
  endtask

  int          n, a1, a2;
  logic [31:0] d;
  logic [1:0]  s;

  initial begin
    rstn = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_sel_i = 4'd0; cmd_adr_i = 32'd0; cmd_dat_i = 32'd0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'd0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rstn = 1'b1;
    #1 chk("ready_before_first_edge", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    #1 chk("ready_first_edge", 32'(cmd_ready_o), 32'd1);

    // write, two wait states
    do_txn(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, K_ACK, 2, 32'h5555_AAAA, 0, 1'b0, n, a1, d, s);
    chk("wr_cyc_len", 32'(n), 32'd3);
    chk("wr_status", 32'(s), 32'd0);
    chk("wr_rdat", d, 32'd0);

    // zero-wait reads back to back
    do_txn(1'b0, 4'hF, 32'h3000_0000, 32'd0, K_ACK, 0, 32'h1234_5678, 0, 1'b0, n, a1, d, s);
    chk("rd_dat", d, 32'h1234_5678);
    chk("rd_status", 32'(s), 32'd0);
    chk("rd_cyc_len", 32'(n), 32'd1);
    do_txn(1'b0, 4'h3, 32'h3000_0008, 32'd0, K_ACK, 0, 32'h0F0F_0F0F, 0, 1'b0, n, a2, d, s);
    chk("accept_to_accept_cycles", 32'(a2 - a1 + 1), 32'd4);
    chk("rd2_dat", d, 32'h0F0F_0F0F);

    // timeout
    do_txn(1'b0, 4'hF, 32'h3000_0010, 32'd0, K_NONE, 0, 32'h1111_2222, 0, 1'b0, n, a1, d, s);
    chk("tmo_cyc_len", 32'(n), 32'd9);
    chk("tmo_status", 32'(s), 32'd2);
    chk("tmo_rdat", d, 32'd0);

    // error alone, right after the timeout
    do_txn(1'b1, 4'h1, 32'h3000_0014, 32'h0000_00AA, K_ERR, 0, 32'h3333_4444, 0, 1'b0, n, a1, d, s);
    chk("accept_after_tmo", 32'(a1 >= 0), 32'd1);
    chk("err_status", 32'(s), 32'd1);
    chk("err_rdat", d, 32'd0);

    // ack and err together
    do_txn(1'b0, 4'hC, 32'h3000_0018, 32'd0, K_BOTH, 1, 32'h7777_8888, 0, 1'b0, n, a1, d, s);
    chk("both_status", 32'(s), 32'd1);
    chk("both_rdat", d, 32'd0);
    chk("both_cyc_len", 32'(n), 32'd2);

    // ack on the timeout cycle itself
    do_txn(1'b0, 4'hF, 32'h3000_001C, 32'd0, K_ACK, TMO, 32'hCAFE_0001, 0, 1'b0, n, a1, d, s);
    chk("ack_at_tmo_status", 32'(s), 32'd0);
    chk("ack_at_tmo_cyc_len", 32'(n), 32'd9);
    chk("ack_at_tmo_dat", d, 32'hCAFE_0001);

    // response backpressure with stray ack/err while waiting
    do_txn(1'b0, 4'h6, 32'h3000_0020, 32'd0, K_ACK, 0, 32'hA5A5_5A5A, 5, 1'b1, n, a1, d, s);
    chk("bp_dat", d, 32'hA5A5_5A5A);
    chk("bp_status", 32'(s), 32'd0);

    // reset in the middle of a bus cycle
    exp_q.push_back(predict(1'b1, 4'hF, 32'h3000_0024, 32'h0BAD_CAFE, K_NONE, 0, 32'd0));
    cmd_we_i = 1'b1; cmd_sel_i = 4'hF; cmd_adr_i = 32'h3000_0024; cmd_dat_i = 32'h0BAD_CAFE;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
    #1 rstn = 1'b0;
    #1 chk("rst_drops_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_drops_stb", 32'(wbm_stb_o), 32'd0);
    @(negedge clk);
    #1 rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("no_rsp_after_rst", 32'(rsp_valid_o), 32'd0);

    // normal traffic after the reset
    do_txn(1'b1, 4'h9, 32'h3000_0028, 32'h1357_9BDF, K_ACK, 1, 32'h2468_ACE0, 0, 1'b0, n, a1, d, s);
    chk("post_rst_status", 32'(s), 32'd0);
    chk("post_rst_cyc_len", 32'(n), 32'd2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
